// File: rtl/mux_pkg.sv
// Shared definitions for the two-channel valid/ready arbiter.
//   WIDTH_DEF : default data width of each channel and of the output.
//   state_t   : arbiter FSM states (IDLE, LOCK0, LOCK1).
package mux_pkg;

  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

endpackage

// File: rtl/mux2x1.sv
// Plain 2:1 data selector used as the arbiter datapath.
//   I0, I1 : candidate data words
//   s      : select (0 -> I0, 1 -> I1)
//   y      : selected word, combinational
module mux2x1
  import mux_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] I0,
  input  logic [WIDTH-1:0] I1,
  input  logic             s,
  output logic [WIDTH-1:0] y
);

  assign y = s ? I1 : I0;

endmodule

// File: rtl/mux2x1_arb.sv
// Merges two valid/ready streams into one registered output stream.
// Round-robin arbitration between bursts; once a channel wins, it keeps the
// grant until it delivers a beat with its last flag set.
//   clk, rst_n     : clock, asynchronous active-low reset
//   I0, v0, l0, r0 : channel 0 data / valid / last / ready
//   I1, v1, l1, r1 : channel 1 data / valid / last / ready
//   y, yv, yl, yr  : output data / valid / last, downstream ready
//   s              : channel that supplied the beat currently held in y
module mux2x1_arb
  import mux_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] I0,
  input  logic             v0,
  input  logic             l0,
  output logic             r0,
  input  logic [WIDTH-1:0] I1,
  input  logic             v1,
  input  logic             l1,
  output logic             r1,
  output logic [WIDTH-1:0] y,
  output logic             yv,
  output logic             yl,
  input  logic             yr,
  output logic             s
);

  state_t           state;
  state_t           state_nxt;
  logic             ptr;       // last granted channel
  logic             gnt;       // channel granted this cycle
  logic             gnt_vld;   // a grant exists this cycle
  logic             can_load;
  logic             v_g;
  logic             l_g;
  logic             xfer;
  logic [WIDTH-1:0] d_g;

  // Output register is free when empty or when it drains this cycle.
  assign can_load = !yv || yr;
  assign v_g      = gnt ? v1 : v0;
  assign l_g      = gnt ? l1 : l0;
  assign xfer     = can_load && gnt_vld && v_g;

  mux2x1 #(
    .WIDTH(WIDTH)
  ) u_mux (
    .I0(I0),
    .I1(I1),
    .s (gnt),
    .y (d_g)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state: lock onto a channel until its last beat transfers
  always_comb begin
    state_nxt = state;
    if (xfer) begin
      if (l_g) begin
        state_nxt = IDLE;
      end else begin
        state_nxt = gnt ? LOCK1 : LOCK0;
      end
    end else if (state != IDLE && state != LOCK0 && state != LOCK1) begin
      state_nxt = IDLE;
    end
  end

  // FSM outputs: grant and readies
  always_comb begin
    gnt     = 1'b0;
    gnt_vld = 1'b0;
    case (state)
      IDLE: begin
        if (v0 && v1) begin
          // Contention goes to the channel that did not win last time.
          gnt_vld = 1'b1;
          gnt     = ~ptr;
        end else if (v0) begin
          gnt_vld = 1'b1;
          gnt     = 1'b0;
        end else if (v1) begin
          gnt_vld = 1'b1;
          gnt     = 1'b1;
        end
      end
      LOCK0: begin
        gnt_vld = 1'b1;
        gnt     = 1'b0;
      end
      LOCK1: begin
        gnt_vld = 1'b1;
        gnt     = 1'b1;
      end
      default: begin
        gnt_vld = 1'b0;
        gnt     = 1'b0;
      end
    endcase
    // Readies are forced low while reset is held, independent of state.
    r0 = rst_n && can_load && gnt_vld && !gnt;
    r1 = rst_n && can_load && gnt_vld && gnt;
  end

  // Output register and round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y   <= '0;
      yv  <= 1'b0;
      yl  <= 1'b0;
      s   <= 1'b0;
      ptr <= 1'b1;
    end else if (xfer) begin
      y   <= d_g;
      yv  <= 1'b1;
      yl  <= l_g;
      s   <= gnt;
      ptr <= gnt;
    end else if (can_load) begin
      yv  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux2x1_arb.sv
module tb_mux2x1_arb;

  logic       clk;
  logic       rst_n;
  logic [7:0] I0, I1;
  logic       v0, l0, v1, l1, yr;
  logic       r0, r1, yv, yl, s;
  logic [7:0] y;

  int n_chk;
  int n_fail;

  // Behavioural model: lock holds the channel owning an open burst (-1 none)
  int         m_lock;
  int         m_ptr;
  logic [7:0] m_y;
  logic       m_yv, m_yl, m_s;

  mux2x1_arb #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .I0(I0), .v0(v0), .l0(l0), .r0(r0),
    .I1(I1), .v1(v1), .l1(l1), .r1(r1),
    .y(y), .yv(yv), .yl(yl), .yr(yr), .s(s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_lock = -1;
    m_ptr  = 1;
    m_y    = 8'h00;
    m_yv   = 1'b0;
    m_yl   = 1'b0;
    m_s    = 1'b0;
  endtask

  // Which channel the rules grant right now (-1 = nobody)
  function automatic int m_grant();
    if (m_lock >= 0) return m_lock;
    if (v0 && v1)    return 1 - m_ptr;
    if (v0)          return 0;
    if (v1)          return 1;
    return -1;
  endfunction

  function automatic logic m_can();
    return !m_yv || yr;
  endfunction

  task automatic model_step();
    int   g;
    logic vg, lg;
    if (!rst_n) begin
      model_reset();
      return;
    end
    g  = m_grant();
    vg = (g == 0) ? v0 : (g == 1) ? v1 : 1'b0;
    lg = (g == 0) ? l0 : l1;
    if (m_can() && vg) begin
      m_y    = (g == 0) ? I0 : I1;
      m_yl   = lg;
      m_s    = (g == 1);
      m_yv   = 1'b1;
      m_ptr  = g;
      m_lock = lg ? -1 : g;
    end else if (m_can()) begin
      m_yv = 1'b0;
    end
  endtask

  task automatic compare();
    int   g;
    logic er0, er1;
    g   = m_grant();
    er0 = rst_n && m_can() && (g == 0);
    er1 = rst_n && m_can() && (g == 1);
    chk("r0", {31'd0, r0}, {31'd0, er0});
    chk("r1", {31'd0, r1}, {31'd0, er1});
    chk("yv", {31'd0, yv}, {31'd0, m_yv});
    chk("y",  {24'd0, y},  {24'd0, m_y});
    chk("yl", {31'd0, yl}, {31'd0, m_yl});
    chk("s",  {31'd0, s},  {31'd0, m_s});
  endtask

  // Compare on the falling edge, advance model, return 1 unit after rising edge
  task automatic cycle();
    @(negedge clk);
    compare();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic a_v0, input logic [7:0] a_i0, input logic a_l0,
                       input logic a_v1, input logic [7:0] a_i1, input logic a_l1,
                       input logic a_yr);
    v0 = a_v0; I0 = a_i0; l0 = a_l0;
    v1 = a_v1; I1 = a_i1; l1 = a_l1;
    yr = a_yr;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    model_reset();
    drive(1, 8'h00, 1, 1, 8'h00, 1, 1);

    // Reset held with both channels valid
    rst_n = 1'b0;
    #2;
    chk("rst_r0", {31'd0, r0}, 32'd0);
    chk("rst_r1", {31'd0, r1}, 32'd0);
    chk("rst_yv", {31'd0, yv}, 32'd0);
    chk("rst_s",  {31'd0, s},  32'd0);
    chk("rst_y",  {24'd0, y},  32'd0);
    cycle();
    cycle();
    rst_n = 1'b1;

    // Contention: ch0 first, then alternate
    drive(1, 8'hA5, 1, 1, 8'h5A, 1, 1);
    #1;
    chk("cont_r0_first", {31'd0, r0}, 32'd1);
    cycle();
    chk("cont_y0", {24'd0, y}, 32'hA5);
    chk("cont_s0", {31'd0, s}, 32'd0);
    cycle();
    chk("cont_y1", {24'd0, y}, 32'h5A);
    chk("cont_s1", {31'd0, s}, 32'd1);
    cycle();
    chk("cont_y2", {24'd0, y}, 32'hA5);
    chk("cont_s2", {31'd0, s}, 32'd0);

    // Give ch1 one beat so ch0 wins the next contention
    drive(0, 8'h00, 1, 1, 8'h66, 1, 1);
    cycle();
    chk("pre_y", {24'd0, y}, 32'h66);

    // Burst lock: ch0 sends 11,22,33 while ch1 stays valid
    drive(1, 8'h11, 0, 1, 8'h77, 1, 1);
    cycle();
    chk("burst_y0", {24'd0, y}, 32'h11);
    chk("burst_s0", {31'd0, s}, 32'd0);
    I0 = 8'h22;
    #1;
    chk("burst_r1_locked_out", {31'd0, r1}, 32'd0);
    cycle();
    chk("burst_y1", {24'd0, y}, 32'h22);
    chk("burst_s1", {31'd0, s}, 32'd0);
    I0 = 8'h33; l0 = 1'b1;
    cycle();
    chk("burst_y2", {24'd0, y}, 32'h33);
    chk("burst_yl2", {31'd0, yl}, 32'd1);
    cycle();
    chk("burst_after_y", {24'd0, y}, 32'h77);
    chk("burst_after_s", {31'd0, s}, 32'd1);

    // Backpressure on a held 3C
    drive(1, 8'h3C, 1, 0, 8'h00, 1, 1);
    cycle();
    chk("bp_load", {24'd0, y}, 32'h3C);
    drive(1, 8'h44, 1, 0, 8'h00, 1, 0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("bp_y_hold", {24'd0, y}, 32'h3C);
      chk("bp_yv_hold", {31'd0, yv}, 32'd1);
      chk("bp_r0", {31'd0, r0}, 32'd0);
      chk("bp_r1", {31'd0, r1}, 32'd0);
    end
    yr = 1'b1;
    #1;
    chk("bp_r0_release", {31'd0, r0}, 32'd1);
    cycle();
    chk("bp_next", {24'd0, y}, 32'h44);

    // Mid-burst reset during a ch1 burst
    drive(0, 8'h00, 1, 1, 8'h91, 0, 1);
    cycle();
    chk("mid_y", {24'd0, y}, 32'h91);
    v0 = 1'b1;
    #1;
    chk("mid_lock_r0", {31'd0, r0}, 32'd0);
    chk("mid_lock_r1", {31'd0, r1}, 32'd1);
    rst_n = 1'b0;
    model_reset();
    #2;
    chk("mid_rst_yv", {31'd0, yv}, 32'd0);
    chk("mid_rst_r1", {31'd0, r1}, 32'd0);
    cycle();
    rst_n = 1'b1;
    drive(1, 8'h0A, 1, 1, 8'h0B, 1, 1);
    cycle();
    chk("mid_after_y", {24'd0, y}, 32'h0A);
    chk("mid_after_s", {31'd0, s}, 32'd0);

    // Idle: output drains, data holds
    drive(0, 8'hFF, 1, 0, 8'hEE, 1, 1);
    cycle();
    chk("idle_yv", {31'd0, yv}, 32'd0);
    chk("idle_y",  {24'd0, y},  32'h0A);
    cycle();

    // Randomized traffic with occasional resets
    for (int i = 0; i < 2000; i++) begin
      v0 = ($urandom_range(0, 9) < 6);
      v1 = ($urandom_range(0, 9) < 6);
      l0 = ($urandom_range(0, 3) == 0);
      l1 = ($urandom_range(0, 3) == 0);
      I0 = 8'($urandom);
      I1 = 8'($urandom);
      yr = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 299) == 0) begin
        rst_n = 1'b0;
        model_reset();
        cycle();
        rst_n = 1'b1;
      end
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mux2x1_arb.md
MUX2X1_ARB -- requirements
Module: mux2x1_arb

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  WIDTH  8  data width of each input channel and of the output.
REQ-002 Ports SHALL be, one per line (name  direction  width  meaning):
  clk  input  1  single clock; all state updates on the rising edge.
  rst_n  input  1  asynchronous, active-low reset.
  I0  input  WIDTH  channel 0 data.
  v0  input  1  channel 0 valid.
  l0  input  1  channel 0 last beat of burst.
  r0  output  1  channel 0 ready.
  I1  input  WIDTH  channel 1 data.
  v1  input  1  channel 1 valid.
  l1  input  1  channel 1 last beat of burst.
  r1  output  1  channel 1 ready.
  y  output  WIDTH  registered output data.
  yv  output  1  output valid.
  yl  output  1  output last flag.
  yr  input  1  downstream ready.
  s  output  1  registered select: source channel of the beat currently in y.

Function
REQ-003 Block SHALL merge two valid/ready streams into one through an internal 2:1 selection, driving s for the selection.
REQ-004 A beat transfers on a channel when vN=1 and rN=1 at a rising edge; the output transfers when yv=1 and yr=1.
REQ-005 The output register SHALL accept a new beat when it is empty or drains in the same cycle: can_load = !yv || yr.
REQ-006 rN SHALL be combinational: rN = can_load && (granted channel == N); the non-granted channel's ready SHALL be 0.
REQ-007 Latency SHALL be 1 cycle from input transfer to yv=1 with y, yl and s updated; sustained throughput SHALL be 1 beat per cycle.
REQ-008 If can_load=1 and no granted input transfers, yv SHALL drop to 0 after an output transfer; y, yl and s SHALL hold their values.
REQ-009 The FSM SHALL have states IDLE, LOCK0 and LOCK1.
REQ-010 In IDLE the grant SHALL be round-robin:
  - only one vN=1: grant that channel.
  - both valid: grant the channel other than the last-granted pointer ptr.
  - neither valid: no grant, r0=r1=0.
REQ-011 On a granted transfer with lN=0, the FSM SHALL move to LOCKN.
REQ-012 On a granted transfer with lN=1, the FSM SHALL stay in or return to IDLE.
REQ-013 On every granted transfer, ptr SHALL be set to N.
REQ-014 In LOCKN the grant SHALL stay on channel N regardless of the other channel's valid.
REQ-015 LOCKN SHALL return to IDLE only on a transfer of channel N with lN=1; while vN=0 it SHALL wait without changing state.
REQ-016 Output hold: while yv=1 and yr=0, y, yl, s and yv SHALL remain stable.
REQ-017 Input data SHALL pass through unmodified: no width change and no arithmetic.

Reset
REQ-018 While rst_n=0, all of the following SHALL hold, asynchronously: yv=0, y=0, yl=0, s=0, state=IDLE, ptr=1 (so channel 0 wins the first contention), r0=r1=0.
REQ-019 Reset asserted mid-burst or with a beat pending in y SHALL discard that state; after release, arbitration SHALL restart from IDLE.
REQ-020 Reset release SHALL take effect on the first rising clk edge after rst_n rises.

Structure
REQ-021 State encodings (IDLE=2'd0, LOCK0=2'd1, LOCK1=2'd2) SHALL live in a shared package mux_pkg, together with the default WIDTH constant.
REQ-022 The datapath selection SHALL instantiate one sub-module, mux2x1 (ports I0, I1, s, y), at WIDTH bits, driven by the next-grant signal.
REQ-023 The FSM, round-robin pointer and output register SHALL be in mux2x1_arb itself; target size is roughly 150-250 lines.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
  - Reset: hold rst_n=0 with v0=v1=1 -> r0=r1=0, yv=0, s=0.
  - Contention: v0=v1=1, l0=l1=1, yr=1, I0=8'hA5, I1=8'h5A -> y sequence A5,5A,A5,... with s toggling 0,1,0.
  - Burst lock: ch0 sends 3 beats (11,22,33 with l0=0,0,1) while v1=1 -> three ch0 beats with s=0, then ch1 granted.
  - Backpressure: yr=0 for 3 cycles with yv=1, y=8'h3C -> y stable at 3C and r0=r1=0; yr=1 -> next beat loads in the same cycle.
  - Mid-burst reset: after one beat of a 3-beat ch1 burst, pulse rst_n low -> yv=0, state IDLE; v0=v1=1 afterwards -> ch0 granted first.
  - Idle: v0=v1=0 with yr=1 -> yv drops one cycle after the last transfer, and y holds its last value.
